// File: rtl/rat_ckpt.sv
// -----------------------------------------------------------------------------
// rat_ckpt : multi-lane register alias table with branch checkpoints.
//
// Renames up to RN_WIDTH instructions per cycle. Sources and rd that an older
// lane of the same group writes are bypassed from that lane. Ready bits are kept
// per logical register and are set by the CDB_PORTS completion buses. Each of
// NUM_CKPT slots holds a copy of the map and ready bits taken at a branch, so a
// mispredict restores in one cycle. A full ROB flush reloads the committed
// (retirement) map.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   ren_valid          per lane: the lane carries an instruction
//   ren_rs1/rs2/rd     per lane: logical sources and destination
//   ren_rd_alloc       per lane: the lane writes rd
//   ren_pd_new         per lane: physical register granted by the free list
//   ckpt_req/lane      take a snapshot after lane ckpt_lane
//   ren_accept         group is committed this edge (low only when full)
//   ps1/ps2, *_ready   per lane: source mappings and availability
//   rd_old_pd          per lane: prior mapping of rd (0 when rd is x0)
//   ckpt_id            slot that a checkpoint request receives (tail)
//   ckpt_full          no slot is free for a new checkpoint
//   cdb_valid/cdb_pd   completion buses
//   br_valid/br_mispredict/br_ckpt_id   branch resolution
//   flush_valid/rrat_map                full flush to the committed map
// -----------------------------------------------------------------------------
module rat_ckpt #(
  parameter int LOG_REGS  = 32,
  parameter int PHY_REGS  = 64,
  parameter int RN_WIDTH  = 2,
  parameter int CDB_PORTS = 2,
  parameter int NUM_CKPT  = 4,
  localparam int LOG_BITS  = $clog2(LOG_REGS),
  localparam int PRF_BITS  = $clog2(PHY_REGS),
  localparam int CK_BITS   = $clog2(NUM_CKPT),
  localparam int LANE_BITS = (RN_WIDTH > 1) ? $clog2(RN_WIDTH) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [RN_WIDTH-1:0]                 ren_valid,
  input  logic [RN_WIDTH-1:0][LOG_BITS-1:0]   ren_rs1,
  input  logic [RN_WIDTH-1:0][LOG_BITS-1:0]   ren_rs2,
  input  logic [RN_WIDTH-1:0][LOG_BITS-1:0]   ren_rd,
  input  logic [RN_WIDTH-1:0]                 ren_rd_alloc,
  input  logic [RN_WIDTH-1:0][PRF_BITS-1:0]   ren_pd_new,
  input  logic                                ckpt_req,
  input  logic [LANE_BITS-1:0]                ckpt_lane,
  output logic                                ren_accept,
  output logic [RN_WIDTH-1:0][PRF_BITS-1:0]   ps1,
  output logic [RN_WIDTH-1:0][PRF_BITS-1:0]   ps2,
  output logic [RN_WIDTH-1:0]                 ps1_ready,
  output logic [RN_WIDTH-1:0]                 ps2_ready,
  output logic [RN_WIDTH-1:0][PRF_BITS-1:0]   rd_old_pd,
  output logic [CK_BITS-1:0]                  ckpt_id,
  output logic                                ckpt_full,
  input  logic [CDB_PORTS-1:0]                cdb_valid,
  input  logic [CDB_PORTS-1:0][PRF_BITS-1:0]  cdb_pd,
  input  logic                                br_valid,
  input  logic                                br_mispredict,
  input  logic [CK_BITS-1:0]                  br_ckpt_id,
  input  logic                                flush_valid,
  input  logic [LOG_REGS-1:0][PRF_BITS-1:0]   rrat_map
);

  // Architectural state
  logic [LOG_REGS-1:0][PRF_BITS-1:0] r_map;
  logic [LOG_REGS-1:0]               r_rdy;
  logic [LOG_REGS-1:0][PRF_BITS-1:0] r_snap_map [NUM_CKPT];
  logic [LOG_REGS-1:0]               r_snap_rdy [NUM_CKPT];
  logic [NUM_CKPT-1:0]               r_live;
  logic [CK_BITS-1:0]                r_head;
  logic [CK_BITS-1:0]                r_tail;
  logic [CK_BITS:0]                  r_count;

  // Combinational next-state
  logic [RN_WIDTH-1:0]               w_lane_wr;
  logic                              w_accept;
  logic                              w_mis;
  logic                              w_resolve;
  logic                              w_ren_go;
  logic                              w_cap;
  logic [LOG_REGS-1:0][PRF_BITS-1:0] w_map_nxt;
  logic [LOG_REGS-1:0]               w_rdy_nxt;
  logic [LOG_REGS-1:0][PRF_BITS-1:0] w_cap_map;
  logic [LOG_REGS-1:0]               w_cap_rdy;
  logic [NUM_CKPT-1:0]               w_kill;
  logic [NUM_CKPT-1:0]               w_live_nxt;
  logic [CK_BITS-1:0]                w_head_nxt;
  logic [CK_BITS-1:0]                w_tail_nxt;
  logic [CK_BITS:0]                  w_count_nxt;

  // True when any valid completion bus carries this physical register.
  function automatic logic f_cdb_hit(input logic [PRF_BITS-1:0] pd);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < CDB_PORTS; p++) begin
      hit = hit | (cdb_valid[p] && (cdb_pd[p] == pd));
    end
    return hit;
  endfunction

  // Rows of a map whose physical register completes this cycle.
  function automatic logic [LOG_REGS-1:0] f_cdb_rows(
    input logic [LOG_REGS-1:0][PRF_BITS-1:0] m
  );
    logic [LOG_REGS-1:0] rows;
    rows = '0;
    for (int r = 0; r < LOG_REGS; r++) begin
      rows[r] = f_cdb_hit(m[r]);
    end
    return rows;
  endfunction

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < RN_WIDTH; i++) begin
      w_lane_wr[i] = ren_valid[i] && ren_rd_alloc[i] && (ren_rd[i] != '0);
    end
  end

  // Besides the live count, a live slot sitting at the tail means an older
  // branch still owns it even though a younger one resolved first; the ring
  // cannot accept another checkpoint until that slot is released.
  assign ckpt_full  = (r_count == (CK_BITS+1)'(NUM_CKPT)) || r_live[r_tail];
  assign ckpt_id    = r_tail;
  assign w_accept   = !(ckpt_req && ckpt_full);
  assign ren_accept = w_accept;

  // Resolutions that name a non-live slot are ignored.
  assign w_mis     = br_valid && br_mispredict && r_live[br_ckpt_id] && !flush_valid;
  assign w_resolve = br_valid && !br_mispredict && r_live[br_ckpt_id] && !flush_valid;
  assign w_ren_go  = w_accept && !flush_valid && !w_mis;
  assign w_cap     = w_ren_go && ckpt_req;

  // ---------------------------------------------------------------------------
  // Source / old-destination lookup with intra-group bypass
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int j = 0; j < RN_WIDTH; j++) begin
      ps1[j]       = r_map[ren_rs1[j]];
      ps1_ready[j] = r_rdy[ren_rs1[j]] | f_cdb_hit(r_map[ren_rs1[j]]);
      ps2[j]       = r_map[ren_rs2[j]];
      ps2_ready[j] = r_rdy[ren_rs2[j]] | f_cdb_hit(r_map[ren_rs2[j]]);
      rd_old_pd[j] = r_map[ren_rd[j]];
      // Ascending scan: a later (younger) matching lane overwrites an earlier one.
      for (int i = 0; i < j; i++) begin
        if (w_lane_wr[i] && (ren_rd[i] == ren_rs1[j])) begin
          ps1[j]       = ren_pd_new[i];
          ps1_ready[j] = 1'b0;
        end
        if (w_lane_wr[i] && (ren_rd[i] == ren_rs2[j])) begin
          ps2[j]       = ren_pd_new[i];
          ps2_ready[j] = 1'b0;
        end
        if (w_lane_wr[i] && (ren_rd[i] == ren_rd[j])) begin
          rd_old_pd[j] = ren_pd_new[i];
        end
      end
      if (ren_rs1[j] == '0) begin
        ps1[j]       = '0;
        ps1_ready[j] = 1'b1;
      end
      if (ren_rs2[j] == '0) begin
        ps2[j]       = '0;
        ps2_ready[j] = 1'b1;
      end
      if (ren_rd[j] == '0) begin
        rd_old_pd[j] = '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next map / ready and checkpoint capture
  // ---------------------------------------------------------------------------
  always_comb begin
    // CDB sets use the mapping held before this cycle's renames.
    w_map_nxt = r_map;
    w_rdy_nxt = r_rdy | f_cdb_rows(r_map);
    w_cap_map = w_map_nxt;
    w_cap_rdy = w_rdy_nxt;
    for (int i = 0; i < RN_WIDTH; i++) begin
      if (w_ren_go && w_lane_wr[i]) begin
        w_map_nxt[ren_rd[i]] = ren_pd_new[i];
        // The new mapping replaces any CDB set aimed at the old one; it is
        // ready only if its own register is broadcast in this same cycle.
        w_rdy_nxt[ren_rd[i]] = f_cdb_hit(ren_pd_new[i]);
      end
      if (LANE_BITS'(i) == ckpt_lane) begin
        w_cap_map = w_map_nxt;
        w_cap_rdy = w_rdy_nxt;
      end
    end
    if (flush_valid) begin
      w_map_nxt = rrat_map;
      w_rdy_nxt = '1;
    end else if (w_mis) begin
      w_map_nxt = r_snap_map[br_ckpt_id];
      w_rdy_nxt = r_snap_rdy[br_ckpt_id] | f_cdb_rows(r_snap_map[br_ckpt_id]);
    end
    w_map_nxt[0] = '0;
    w_rdy_nxt[0] = 1'b1;
    w_cap_map[0] = '0;
    w_cap_rdy[0] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Checkpoint ring: live bits, head, tail, count
  // ---------------------------------------------------------------------------
  // A mispredict kills its own slot and every younger one up to the tail. When
  // the tail has wrapped onto the mispredicted slot the whole ring is younger.
  always_comb begin
    for (int k = 0; k < NUM_CKPT; k++) begin
      w_kill[k] = ((r_tail - br_ckpt_id) == '0) ||
                  (CK_BITS'(CK_BITS'(k) - br_ckpt_id) < CK_BITS'(r_tail - br_ckpt_id));
    end
  end

  always_comb begin
    w_live_nxt  = r_live;
    w_tail_nxt  = r_tail;
    w_head_nxt  = r_head;
    w_count_nxt = '0;
    // Head walks one dead slot per cycle; it stops at a live slot, or at the
    // tail once nothing is live.
    if (!r_live[r_head] && ((r_head != r_tail) || (r_count != '0))) begin
      w_head_nxt = r_head + CK_BITS'(1);
    end
    if (flush_valid) begin
      w_live_nxt = '0;
      w_tail_nxt = '0;
      w_head_nxt = '0;
    end else if (w_mis) begin
      w_live_nxt = r_live & ~w_kill;
      w_tail_nxt = br_ckpt_id;
    end else begin
      if (w_resolve) begin
        w_live_nxt[br_ckpt_id] = 1'b0;
      end
      if (w_cap) begin
        w_live_nxt[r_tail] = 1'b1;
        w_tail_nxt         = r_tail + CK_BITS'(1);
      end
    end
    for (int k = 0; k < NUM_CKPT; k++) begin
      w_count_nxt = w_count_nxt + (CK_BITS+1)'(w_live_nxt[k]);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LOG_REGS; i++) begin
        r_map[i] <= (i < PHY_REGS) ? PRF_BITS'(i) : '0;
      end
      r_rdy   <= '1;
      r_live  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_map   <= w_map_nxt;
      r_rdy   <= w_rdy_nxt;
      r_live  <= w_live_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Snapshot storage carries no reset; only live slots are ever read.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CKPT; k++) begin
      if (w_cap && (CK_BITS'(k) == r_tail)) begin
        r_snap_map[k] <= w_cap_map;
        r_snap_rdy[k] <= w_cap_rdy;
      end else if (r_live[k]) begin
        r_snap_rdy[k] <= r_snap_rdy[k] | f_cdb_rows(r_snap_map[k]);
      end
    end
  end

endmodule
